usrt_apb_requester: RTL and testbench

- APB initiator that drives the USRT peripheral's APB slave port (pWData/pRData/pWrite/pSelect/pEnable/pAddress/pReady).
- Converts a simple valid/ready command stream into APB setup/access transfers and returns read data on a valid/ready response stream.
- Used as the on-chip bus master for the USRT block and as the reusable bus driver for system-level benches.

---
 rtl/usrt_apb_requester.sv | 136 +++++++++++++
 tb/tb_usrt_apb_requester.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_apb_requester.sv
// APB initiator for the USRT slave port: valid/ready command in, APB setup/access, response out.
// Optional ACCESS-phase timeout abort enabled by defining APB_TIMEOUT_EN.
module usrt_apb_requester #(
   parameter int unsigned ADDR_WIDTH     = 33,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                  pClk,
   input  logic                  pReset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] pAddress,
   output logic                  pWrite,
   output logic [DATA_WIDTH-1:0] pWData,
   output logic                  pSelect,
   output logic                  pEnable,
   input  logic [DATA_WIDTH-1:0] pRData,
   input  logic                  pReady
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                  state_q, state_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
`ifdef APB_TIMEOUT_EN
   logic                    err_q, err_d;
   logic [15:0]             cnt_q, cnt_d;
`endif

   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         state_q <= StIdle;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
         err_q   <= 1'b0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef APB_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef APB_TIMEOUT_EN
      err_d   = err_q;
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_write ? cmd_wdata : '0;
               state_d = StSetup;
            end
         end
         StSetup: begin
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = StAccess;
         end
         StAccess: begin
            if (pReady) begin
               rdata_d = write_q ? '0 : pRData;
`ifdef APB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = StResp;
`ifdef APB_TIMEOUT_EN
            end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
               // This is the TIMEOUT_CYCLES-th stalled cycle: abort the transfer
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d   = cnt_q + 16'd1;
`endif
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == StIdle);
      pSelect   = (state_q == StSetup) || (state_q == StAccess);
      pEnable   = (state_q == StAccess);
      rsp_valid = (state_q == StResp);
      pAddress  = addr_q;
      pWrite    = write_q;
      pWData    = wdata_q;
      rsp_rdata = rdata_q;
`ifdef APB_TIMEOUT_EN
      rsp_err   = err_q;
`else
      rsp_err   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_usrt_apb_requester.sv
// Self-checking bench for usrt_apb_requester: vector table, corner sequences, randomized transfers.
module tb_usrt_apb_requester;

   localparam int AW = 33;
   localparam int DW = 8;
   localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          pClk;
   logic          pReset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] pAddress;
   logic          pWrite, pSelect, pEnable, pReady;
   logic [DW-1:0] pWData, pRData;

   usrt_apb_requester #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .pClk      (pClk),
      .pReset    (pReset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .pAddress  (pAddress),
      .pWrite    (pWrite),
      .pWData    (pWData),
      .pSelect   (pSelect),
      .pEnable   (pEnable),
      .pRData    (pRData),
      .pReady    (pReady)
   );

   initial pClk = 1'b0;
   always #5 pClk = ~pClk;

   int cyc = 0;
   always @(posedge pClk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int setup_cyc, resp_cyc, rr_cyc;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            waits;
      logic [DW-1:0] prdata;
      int            stall;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge pClk);
      #1;
   endtask

   // Enable without select is never legal on APB
   always @(negedge pClk) begin
      if (pReset === 1'b1) chk("en_without_sel", 64'(pEnable && !pSelect), 64'(0));
   end

   // Runs one transfer from IDLE to IDLE, checking every cycle against the APB rules.
   task automatic xfer(input vec_t v);
      bit            tmo;
      int            n_acc;
      logic [DW-1:0] er;
      logic          ee;
      tmo   = TO_EN && (v.waits >= TO);
      n_acc = tmo ? TO : v.waits + 1;
      er    = tmo ? '0 : v.exp_rdata;
      ee    = tmo ? 1'b1 : v.exp_err;

      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      tick;
      setup_cyc = cyc;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = 33'({$urandom, $urandom});
      cmd_wdata = 8'($urandom);
      pReady    = 1'($urandom);
      rsp_ready = 1'($urandom);
      chk("setup_sel", 64'(pSelect), 64'(1));
      chk("setup_en", 64'(pEnable), 64'(0));
      chk("setup_addr", 64'(pAddress), 64'(v.addr));
      chk("setup_write", 64'(pWrite), 64'(v.wr));
      chk("setup_wdata", 64'(pWData), 64'(v.wr ? v.wdata : 8'h00));
      chk("setup_cmd_ready", 64'(cmd_ready), 64'(0));
      tick;
      for (int i = 0; i < n_acc; i++) begin
         chk("access_sel_en", 64'({pSelect, pEnable}), 64'(3));
         chk("access_addr", 64'(pAddress), 64'(v.addr));
         chk("access_wdata", 64'(pWData), 64'(v.wr ? v.wdata : 8'h00));
         chk("access_rsp_valid", 64'(rsp_valid), 64'(0));
         pReady    = (i == v.waits);
         pRData    = pReady ? v.prdata : 8'($urandom);
         rsp_ready = 1'($urandom);
         tick;
      end
      pReady    = 1'b0;
      rsp_ready = 1'b0;
      resp_cyc  = cyc;
      for (int s = 0; s <= v.stall; s++) begin
         chk("resp_valid", 64'(rsp_valid), 64'(1));
         chk("resp_bus_idle", 64'({pSelect, pEnable}), 64'(0));
         chk("resp_rdata", 64'(rsp_rdata), 64'(er));
         chk("resp_err", 64'(rsp_err), 64'(ee));
         chk("resp_addr_kept", 64'(pAddress), 64'(v.addr));
         chk("resp_cmd_ready", 64'(cmd_ready), 64'(0));
         if (s == v.stall) begin
            rsp_ready = 1'b1;
            rr_cyc    = cyc;
         end else begin
            cmd_valid = 1'b1;
            cmd_addr  = 33'({$urandom, $urandom});
         end
         tick;
      end
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("idle_sel", 64'(pSelect), 64'(0));
   endtask

   initial begin
      vec_t v;
      int   s1, rr1, n;

      vecs[0] = '{1'b1, 33'h0,         8'hFC, 0,  8'h00, 0, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 33'h1_2345_6789, 8'h00, 12, 8'h8E, 0, 8'h8E, 1'b0};
      vecs[2] = '{1'b1, 33'h1_FFFF_FFFF, 8'h55, 3,  8'hA7, 1, 8'h00, 1'b0};
      vecs[3] = '{1'b0, 33'h0_0000_00AA, 8'h99, 3,  8'h3C, 2, 8'h3C, 1'b0};
      vecs[4] = '{1'b0, 33'h7,         8'h00, 0,  8'h00, 0, 8'h00, 1'b0};
      vecs[5] = '{1'b1, 33'h1_0000_0000, 8'h00, 1,  8'hFF, 5, 8'h00, 1'b0};

      pReset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; pRData = '0; pReady = 1'b0;
      #3;
      chk("rst_sel", 64'(pSelect), 64'(0));
      chk("rst_en", 64'(pEnable), 64'(0));
      chk("rst_write", 64'(pWrite), 64'(0));
      chk("rst_addr", 64'(pAddress), 64'(0));
      chk("rst_wdata", 64'(pWData), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rdata", 64'(rsp_rdata), 64'(0));
      chk("rst_err", 64'(rsp_err), 64'(0));
      tick;
      pReset = 1'b1;
      tick;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));

      for (int k = 0; k < 6; k++) begin
         xfer(vecs[k]);
         if (k == 0) chk("rsp_latency_after_accept", 64'(resp_cyc - (setup_cyc - 1)), 64'(3));
      end

      // Response backpressure with a pending command
      xfer(vecs[5]);
      rr1 = rr_cyc;
      xfer(vecs[4]);
      chk("setup_after_rsp_ready", 64'(setup_cyc - rr1), 64'(2));

      // Back-to-back: write 0x55 then read
      v = '{1'b1, 33'h55, 8'h55, 0, 8'h00, 0, 8'h00, 1'b0};
      xfer(v);
      s1 = setup_cyc;
      v = '{1'b0, 33'h56, 8'h00, 0, 8'h6B, 0, 8'h6B, 1'b0};
      xfer(v);
      chk("b2b_setup_spacing", 64'(setup_cyc - s1), 64'(4));

      // Randomized transfers checked against the transfer rules
      for (int r = 0; r < 40; r++) begin
         v.wr        = 1'($urandom);
         v.addr      = 33'({$urandom, $urandom});
         v.wdata     = 8'($urandom);
         v.waits     = int'($urandom_range(0, 6));
         v.prdata    = 8'($urandom);
         v.stall     = int'($urandom_range(0, 2));
         v.exp_rdata = v.wr ? 8'h00 : v.prdata;
         v.exp_err   = 1'b0;
         xfer(v);
      end

      // Reset during ACCESS wait
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 33'h123;
      tick;
      cmd_valid = 1'b0;
      tick;
      repeat (3) tick;
      chk("pre_reset_access", 64'({pSelect, pEnable}), 64'(3));
      #2 pReset = 1'b0;
      #1;
      chk("async_rst_bus", 64'({pSelect, pEnable}), 64'(0));
      chk("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      tick;
      pReset = 1'b1;
      tick;
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("post_rst_addr", 64'(pAddress), 64'(0));

      // Slave never ready
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 33'h1AB;
      tick;
      cmd_valid = 1'b0;
      tick;
      n = 0;
      while (pSelect && pEnable && n < 100) begin
         n++;
         tick;
      end
`ifdef APB_TIMEOUT_EN
      chk("timeout_access_cycles", 64'(n), 64'(TO));
      chk("timeout_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("timeout_err", 64'(rsp_err), 64'(1));
      chk("timeout_rdata", 64'(rsp_rdata), 64'(0));
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("timeout_back_idle", 64'(cmd_ready), 64'(1));
`else
      chk("no_timeout_wait", 64'(n), 64'(100));
      chk("no_timeout_still_access", 64'({pSelect, pEnable}), 64'(3));
      chk("no_timeout_err", 64'(rsp_err), 64'(0));
      pReset = 1'b0;
      tick;
      pReset = 1'b1;
      tick;
      chk("no_timeout_recover", 64'(cmd_ready), 64'(1));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
